// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the IF, ID and EXE stages.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } if_state_e;

  // One fetched instruction together with its return PC (fetch address + step)
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc,inst} holding buffer for a word that returns while the pipe is frozen.
module if_skid_buf
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      unload,
  input  logic      clear,
  input  if_entry_t din,
  output logic      full,
  output if_entry_t dout
);

  // Clear wins; a load in the same cycle as an unload refills the entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, freeze/redirect
// handling and IF/ID boundary registers.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt/stall_cnt counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int unsigned     PC_STEP  = 4
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  if_state_e       state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc_seq;
  logic            accept;
  logic            hold_release;
  logic            fetch_direct;
  logic            skid_load;
  logic            skid_unload;
  logic            skid_clear;
  logic            skid_full;
  logic            if_load;
  if_entry_t       skid_din;
  if_entry_t       skid_q;

  // Request/handshake decode; the request is held in WAIT/DROP until acked
  always_comb begin
    pc_seq       = pc + XLEN'(PC_STEP);
    imem_req     = rst && ((state == WAIT) || (state == DROP) || !freeze);
    imem_addr    = pc;
    accept       = imem_req && imem_ack;
    hold_release = rst && (state == HOLD) && skid_full && !freeze;
    fetch_direct = !br_taken && accept && !freeze &&
                   ((state == FETCH) || (state == WAIT));
    skid_load    = !br_taken && accept &&
                   ((((state == FETCH) || (state == WAIT)) && freeze) || hold_release);
    skid_unload  = !br_taken && hold_release;
    skid_clear   = rst && br_taken;
    if_load      = fetch_direct || skid_unload;
    skid_din     = '{pc: pc_seq, inst: imem_rdata};
  end

  if_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (skid_din),
    .full   (skid_full),
    .dout   (skid_q)
  );

  // FSM, PC and IF/ID registers; redirect has priority over freeze and ack
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= '0;
      pc_out      <= '0;
      inst        <= NOP_INST;
      inst_valid  <= 1'b0;
    end else if (br_taken) begin
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      if (imem_req && !imem_ack) begin
        // Outstanding request must complete at its address; park the target
        redirect_pc <= br_addr;
        state       <= DROP;
      end else begin
        pc    <= br_addr;
        state <= FETCH;
      end
    end else begin
      if (fetch_direct) begin
        pc_out     <= pc_seq;
        inst       <= imem_rdata;
        inst_valid <= 1'b1;
      end else if (skid_unload) begin
        pc_out     <= skid_q.pc;
        inst       <= skid_q.inst;
        inst_valid <= 1'b1;
      end

      case (state)
        FETCH, WAIT: begin
          if (accept) begin
            pc    <= pc_seq;
            state <= freeze ? HOLD : FETCH;
          end else if (imem_req) begin
            state <= WAIT;
          end
        end
        HOLD: begin
          // Release requests the next word at once; an immediate ack refills the skid
          if (hold_release) begin
            if (imem_ack) begin
              pc <= pc_seq;
            end else begin
              state <= WAIT;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Instructions entering IF/ID and frozen cycles, both free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (if_load) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (freeze) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scoreboard of expected IF/ID words plus
// direct checks of the request handshake, freeze, redirect, wrap and reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          fetch_exp = 0;
  int          stall_exp = 0;
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_inst = 32'h0;

  if_stage u_dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .inst       (inst),
    .inst_valid (inst_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc   = a + 32'd4;
    e.inst = mem_word(a);
    sb_q.push_back(e);
    fetch_exp++;
  endtask

  task automatic drv(input logic fr, input logic br, input logic [31:0] ba, input logic ak);
    freeze   = fr;
    br_taken = br;
    br_addr  = ba;
    imem_ack = ak;
    #1;
  endtask

  // One clock; afterwards sample at the falling edge and pop on each new IF/ID word
  task automatic tick();
    exp_t e;
    if (rst && freeze) stall_exp++;
    @(posedge clk);
    @(negedge clk);
    if (inst_valid && (!last_valid || pc_out !== last_pc || inst !== last_inst)) begin
      chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_inst", inst, e.inst);
      end
    end
    last_valid = inst_valid;
    last_pc    = pc_out;
    last_inst  = inst;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    #1 chk("rst_req", 32'(imem_req), 32'd0);
    tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst", inst, 32'h0);

    // T1: zero-wait memory, one instruction per cycle
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'(i * 4));
      imem_rdata = mem_word(32'(i * 4));
      push(32'(i * 4));
      tick();
    end

    // T2: ack three cycles late, address held
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr, 32'h10);
      tick();
    end
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_addr_ack", imem_addr, 32'h10);
    imem_rdata = mem_word(32'h10);
    push(32'h10);
    tick();
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_pc_out", pc_out, 32'h14);

    // T3: ack arrives while frozen, word parked then released
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t3_req_inflight", 32'(imem_req), 32'd1);
    chk("t3_addr_inflight", imem_addr, 32'h14);
    imem_rdata = mem_word(32'h14);
    push(32'h14);
    tick();
    chk("t3_hold_pc", pc_out, 32'h14);
    chk("t3_hold_inst", inst, mem_word(32'h10));
    drv(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t3_req_hold", 32'(imem_req), 32'd0);
    tick();
    chk("t3_hold_pc2", pc_out, 32'h14);
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_req_rel", 32'(imem_req), 32'd1);
    chk("t3_addr_rel", imem_addr, 32'h18);
    tick();
    chk("t3_rel_pc_out", pc_out, 32'h18);
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    imem_rdata = mem_word(32'h18);
    push(32'h18);
    tick();

    // T4: redirect to 0x100 while fetch at 0x20 is outstanding
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    imem_rdata = mem_word(32'h1C);
    push(32'h1C);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drv(1'b0, 1'b1, 32'h100, 1'b0);
    chk("t4_req_br", 32'(imem_req), 32'd1);
    chk("t4_addr_br", imem_addr, 32'h20);
    tick();
    chk("t4_flush_valid", 32'(inst_valid), 32'd0);
    chk("t4_flush_inst", inst, 32'h0);
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t4_req_drop", 32'(imem_req), 32'd1);
    chk("t4_addr_drop", imem_addr, 32'h20);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    imem_rdata = mem_word(32'h20);
    tick();
    chk("t4_dropped_valid", 32'(inst_valid), 32'd0);
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_addr_target", imem_addr, 32'h100);
    imem_rdata = mem_word(32'h100);
    push(32'h100);
    tick();

    // T5: redirect, freeze and ack together
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drv(1'b1, 1'b1, 32'h40, 1'b1);
    imem_rdata = mem_word(32'h104);
    tick();
    chk("t5_flush_valid", 32'(inst_valid), 32'd0);
    chk("t5_flush_inst", inst, 32'h0);
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_addr_target", imem_addr, 32'h40);
    imem_rdata = mem_word(32'h40);
    push(32'h40);
    tick();

    // PC wrap from 0xFFFF_FFFC
    drv(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_req_frozen", 32'(imem_req), 32'd0);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = mem_word(32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_out", pc_out, 32'h0);
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr_next", imem_addr, 32'h0);
    imem_rdata = mem_word(32'h0);
    push(32'h0);
    tick();

    // Newest redirect wins while draining
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drv(1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    drv(1'b0, 1'b1, 32'h300, 1'b0);
    chk("drop_addr_held", imem_addr, 32'h4);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    imem_rdata = mem_word(32'h4);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr_newest", imem_addr, 32'h300);
    tick();
`ifdef IF_PERF_CNT_EN
    chk("cnt_fetch", fetch_cnt, 32'(fetch_exp));
    chk("cnt_stall", stall_cnt, 32'(stall_exp));
`endif

    // T6: reset during WAIT, late ack ignored
    rst = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6_req_rst", 32'(imem_req), 32'd0);
    tick();
    fetch_exp = 0;
    stall_exp = 0;
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    imem_rdata = mem_word(32'h300);
    chk("t6_req_late_ack", 32'(imem_req), 32'd0);
    tick();
    chk("t6_valid", 32'(inst_valid), 32'd0);
    rst = 1'b1;
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("t6_cnt_fetch", fetch_cnt, 32'(fetch_exp));
    chk("t6_cnt_stall", stall_cnt, 32'(stall_exp));
`endif
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    imem_rdata = mem_word(32'h0);
    push(32'h0);
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
